i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter
// Shares one I2C master between two requesters. A requester raises req[n] with
// its address/length/direction; the arbiter grants round-robin, issues one
// command to the master, steers the byte handshakes between the owner and the
// master, pulses done[n] when the last byte moves, then holds a bus-idle gap
// before the next grant.
//
// Ports
//   clock, reset                   system clock, synchronous active-high reset
//   req, reqAddr, reqLen, reqRdWr  per-requester command (n = 0, 1)
//   gnt, done, err                 grant (one-hot), end-of-transaction, watchdog abort
//   txData/txValid/txReady         write bytes from the requesters
//   rxData/rxValid/rxReady         read bytes to the requesters
//   mAddr/mLenMsg/mRdWr/mStart     command to the master
//   mInData/mInValid/mInReady      write bytes to the master
//   mOutData/mOutValid/mOutReady   read bytes from the master
//
// Build option: define I2C_ARB_TIMEOUT_EN to add a watchdog that aborts a
// transfer after TIMEOUT transfer cycles without a byte handshake.
//
// state | meaning
// IDLE  | no owner; grant on any request
// START | owner granted; mStart pulses (or zero-length finishes here)
// XFER  | bytes flow between owner and master
// GAP   | no owner; stop-condition guard of GAP_CYCLES cycles

module i2c_arbiter #(
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [13:0] reqAddr,
    input  logic [15:0] reqLen,
    input  logic [1:0]  reqRdWr,
    output logic [1:0]  gnt,
    input  logic [15:0] txData,
    input  logic [1:0]  txValid,
    output logic [1:0]  txReady,
    output logic [7:0]  rxData,
    output logic [1:0]  rxValid,
    input  logic [1:0]  rxReady,
    output logic [1:0]  done,
    output logic        err,
    output logic [6:0]  mAddr,
    output logic [7:0]  mLenMsg,
    output logic        mRdWr,
    output logic        mStart,
    output logic [7:0]  mInData,
    output logic        mInValid,
    input  logic        mInReady,
    input  logic [7:0]  mOutData,
    input  logic        mOutValid,
    output logic        mOutReady
);

    typedef enum logic [1:0] {IDLE, START, XFER, GAP} state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;      // requester favoured on a tie
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       len_q, len_d;
    logic             rdwr_q, rdwr_d;
    logic             start_q, start_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [1:0]       done_q, done_d;

    logic             win;
    logic [7:0]       len_sel;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    // Byte steering: the only combinational input-to-output paths.
    logic       in_xfer, wr_act, rd_act, xfer_hs;
    logic [7:0] own_tx_data;

    assign in_xfer     = (state_q == XFER);
    assign wr_act      = in_xfer & ~rdwr_q;
    assign rd_act      = in_xfer & rdwr_q;
    assign own_tx_data = owner_q ? txData[15:8] : txData[7:0];

    assign mInData   = wr_act ? own_tx_data : 8'h00;
    assign mInValid  = wr_act & txValid[owner_q];
    assign txReady   = {2{wr_act & mInReady}} & gnt_q;
    assign rxData    = rd_act ? mOutData : 8'h00;
    assign rxValid   = {2{rd_act & mOutValid}} & gnt_q;
    assign mOutReady = rd_act & rxReady[owner_q];
    assign xfer_hs   = (mInValid & mInReady) | (mOutValid & mOutReady);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        addr_d  = addr_q;
        len_d   = len_q;
        rdwr_d  = rdwr_q;
        start_d = 1'b0;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        done_d  = 2'b00;
        win     = 1'b0;
        len_sel = 8'h00;
`ifdef I2C_ARB_TIMEOUT_EN
        wd_d    = wd_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    win     = (req[0] && req[1]) ? prio_q : req[1];
                    len_sel = win ? reqLen[15:8] : reqLen[7:0];
                    owner_d = win;
                    prio_d  = ~win;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    addr_d  = win ? reqAddr[13:7] : reqAddr[6:0];
                    len_d   = len_sel;
                    rdwr_d  = reqRdWr[win];
                    cnt_d   = len_sel;
                    start_d = (len_sel != 8'h00);
                    state_d = START;
                end
            end
            START: begin
                if (len_q == 8'h00) begin
                    done_d  = gnt_q;
                    gnt_d   = 2'b00;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    state_d = XFER;
`ifdef I2C_ARB_TIMEOUT_EN
                    wd_d    = WD_LOAD;
`endif
                end
            end
            XFER: begin
                if (xfer_hs) begin
                    cnt_d = cnt_q - 8'd1;
`ifdef I2C_ARB_TIMEOUT_EN
                    wd_d  = WD_LOAD;
`endif
                    if (cnt_q == 8'd1) begin
                        done_d  = gnt_q;
                        gnt_d   = 2'b00;
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                    end
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (wd_q == '0) begin
                    err_d   = 1'b1;
                    gnt_d   = 2'b00;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
`endif
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            addr_q  <= 7'h00;
            len_q   <= 8'h00;
            rdwr_q  <= 1'b0;
            start_q <= 1'b0;
            cnt_q   <= 8'h00;
            gap_q   <= '0;
            done_q  <= 2'b00;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            rdwr_q  <= rdwr_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign mAddr   = addr_q;
    assign mLenMsg = len_q;
    assign mRdWr   = rdwr_q;
    assign mStart  = start_q;

`ifdef I2C_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    // Without the watchdog TIMEOUT has no effect; keep it referenced.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_arbiter.sv
module tb_i2c_arbiter;
    localparam int GAP = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [13:0] reqAddr;
    logic [15:0] reqLen;
    logic [1:0]  reqRdWr;
    logic [1:0]  gnt;
    logic [15:0] txData;
    logic [1:0]  txValid;
    logic [1:0]  txReady;
    logic [7:0]  rxData;
    logic [1:0]  rxValid;
    logic [1:0]  rxReady;
    logic [1:0]  done;
    logic        err;
    logic [6:0]  mAddr;
    logic [7:0]  mLenMsg;
    logic        mRdWr;
    logic        mStart;
    logic [7:0]  mInData;
    logic        mInValid;
    logic        mInReady;
    logic [7:0]  mOutData;
    logic        mOutValid;
    logic        mOutReady;

    i2c_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(100)) dut (
        .clock(clock), .reset(reset), .req(req), .reqAddr(reqAddr), .reqLen(reqLen),
        .reqRdWr(reqRdWr), .gnt(gnt), .txData(txData), .txValid(txValid), .txReady(txReady),
        .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady), .done(done), .err(err),
        .mAddr(mAddr), .mLenMsg(mLenMsg), .mRdWr(mRdWr), .mStart(mStart),
        .mInData(mInData), .mInValid(mInValid), .mInReady(mInReady),
        .mOutData(mOutData), .mOutValid(mOutValid), .mOutReady(mOutReady)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: requester to favour on a tie, and each requester's command.
    int         favour;
    logic [6:0] t_addr [2];
    int         t_len  [2];
    logic       t_rd   [2];
    logic [7:0] t_bytes[2][16];
    bit         rand_hs;
    int         stall_byte;
    int         stall_cycles;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        req = 2'b00; reqAddr = '0; reqLen = '0; reqRdWr = 2'b00;
        txData = '0; txValid = 2'b00; rxReady = 2'b00;
        mInReady = 1'b0; mOutData = 8'h00; mOutValid = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clear_inputs();
        tick(); tick();
        reset = 1'b0;
        favour = 0;
    endtask

    task automatic setup_req(input int n, input logic [6:0] a, input int len, input logic rd);
        t_addr[n] = a; t_len[n] = len; t_rd[n] = rd;
        for (int i = 0; i < 16; i++) t_bytes[n][i] = 8'($urandom);
        reqAddr[7*n +: 7] = a;
        reqLen[8*n +: 8]  = 8'(len);
        reqRdWr[n]        = rd;
        req[n]            = 1'b1;
    endtask

    // Runs one transaction of requester n, which the model says is granted next.
    // abort_at >= 0 asserts reset while that byte index is being offered.
    task automatic serve(input int n, input int abort_at);
        int waited, idx, stall_left;
        bit reached;
        logic [1:0] oh;
        logic side, m;
        oh = 2'(1 << n);
        waited = 0; idx = 0; reached = 0;
        stall_left = stall_cycles;
        do begin tick(); waited++; end while (gnt === 2'b00 && waited < 200);
        n_cmp++;
        if (gnt !== oh) begin
            n_bad++;
            $display("FAIL grant req%0d: gnt=%b want=%b after %0d cycles", n, gnt, oh, waited);
            req[n] = 1'b0;
            return;
        end
        n_cmp++;
        if (mStart !== (t_len[n] != 0)) begin
            n_bad++; $display("FAIL mStart at grant: got %b want %b", mStart, (t_len[n] != 0));
        end
        if (t_len[n] != 0) begin
            n_cmp++;
            if ({mAddr, mLenMsg, mRdWr} !== {t_addr[n], 8'(t_len[n]), t_rd[n]}) begin
                n_bad++;
                $display("FAIL command: got addr=%h len=%0d rd=%b want addr=%h len=%0d rd=%b",
                         mAddr, mLenMsg, mRdWr, t_addr[n], t_len[n], t_rd[n]);
            end
        end
        // Changes after grant must not reach the master.
        reqAddr[7*n +: 7] = 7'($urandom);
        reqLen[8*n +: 8]  = 8'($urandom);
        reqRdWr[n]        = 1'($urandom);
        for (int c = 0; c < 400; c++) begin
            tick();
            if (idx == t_len[n]) begin reached = 1; break; end
            n_cmp++;
            if ({done, gnt, mStart, err} !== {2'b00, oh, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL xfer status byte %0d: done=%b gnt=%b mStart=%b err=%b want 00/%b/0/0",
                         idx, done, gnt, mStart, err, oh);
            end
            side = rand_hs ? 1'($urandom) : 1'b1;
            m    = rand_hs ? 1'($urandom) : 1'b1;
            if (idx == stall_byte && stall_left > 0) begin side = 1'b0; stall_left--; end
            if (!t_rd[n]) begin
                txValid[n] = side; txData[8*n +: 8] = t_bytes[n][idx]; mInReady = m;
            end else begin
                mOutValid = m; mOutData = t_bytes[n][idx]; rxReady[n] = side;
            end
            if (idx == abort_at) reset = 1'b1;
            #1;
            n_cmp++;
            if (!t_rd[n]) begin
                if ({mInValid, mInData, txReady, rxValid, mOutReady} !==
                    {side, t_bytes[n][idx], (m ? oh : 2'b00), 2'b00, 1'b0}) begin
                    n_bad++;
                    $display("FAIL write path byte %0d: got v=%b d=%h txReady=%b rxValid=%b mOutReady=%b want v=%b d=%h txReady=%b",
                             idx, mInValid, mInData, txReady, rxValid, mOutReady, side, t_bytes[n][idx], (m ? oh : 2'b00));
                end
            end else begin
                if ({rxValid, rxData, mOutReady, mInValid, txReady} !==
                    {(m ? oh : 2'b00), t_bytes[n][idx], side, 1'b0, 2'b00}) begin
                    n_bad++;
                    $display("FAIL read path byte %0d: got rxValid=%b d=%h mOutReady=%b mInValid=%b txReady=%b want rxValid=%b d=%h mOutReady=%b",
                             idx, rxValid, rxData, mOutReady, mInValid, txReady, (m ? oh : 2'b00), t_bytes[n][idx], side);
                end
            end
            if (idx == abort_at) begin
                tick();
                n_cmp++;
                if ({gnt, txReady, rxValid, rxData, done, err, mAddr, mLenMsg, mRdWr, mStart,
                     mInData, mInValid, mOutReady} !== 44'h0) begin
                    n_bad++;
                    $display("FAIL reset outputs: gnt=%b done=%b err=%b mStart=%b mAddr=%h mLenMsg=%h mInValid=%b",
                             gnt, done, err, mStart, mAddr, mLenMsg, mInValid);
                end
                reset = 1'b0;
                clear_inputs();
                favour = 0;
                for (int i = 0; i < 3; i++) begin
                    tick();
                    n_cmp++;
                    if ({done, err, gnt} !== 5'b0) begin
                        n_bad++; $display("FAIL after abort: done=%b err=%b gnt=%b want 0", done, err, gnt);
                    end
                end
                return;
            end
            if (side && m) idx++;
        end
        n_cmp++;
        if (!reached || {done, gnt, err} !== {oh, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL done req%0d: reached=%0d bytes=%0d/%0d done=%b gnt=%b err=%b want done=%b",
                     n, reached, idx, t_len[n], done, gnt, err, oh);
        end
        txValid[n] = 1'b0; rxReady[n] = 1'b0; mInReady = 1'b0; mOutValid = 1'b0;
        req[n] = 1'b0;
        favour = 1 - n;
        for (int i = 1; i < GAP; i++) begin
            tick();
            n_cmp++;
            if ({gnt, done} !== 4'b0) begin
                n_bad++; $display("FAIL gap cycle %0d: gnt=%b done=%b want 0", i, gnt, done);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clear_inputs();
        req = 2'b11; txValid = 2'b11; rxReady = 2'b11; mInReady = 1'b1; mOutValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({gnt, txReady, rxValid, rxData, done, err, mAddr, mLenMsg, mRdWr, mStart,
                 mInData, mInValid, mOutReady} !== 44'h0) begin
                n_bad++;
                $display("FAIL reset state: gnt=%b done=%b err=%b mStart=%b txReady=%b rxValid=%b mOutReady=%b",
                         gnt, done, err, mStart, txReady, rxValid, mOutReady);
            end
        end
        clear_inputs();
        reset = 1'b0;
        favour = 0;
    endtask

    task automatic test_write;
        rand_hs = 0; stall_byte = -1; stall_cycles = 0;
        setup_req(0, 7'h10, 1, 1'b0);
        t_bytes[0][0] = 8'h4A;
        serve(0, -1);
    endtask

    task automatic test_round_robin;
        do_reset();
        rand_hs = 0; stall_byte = -1;
        for (int k = 0; k < 2; k++) begin
            setup_req(0, 7'h30, 2, 1'b0);
            setup_req(1, 7'h31, 1, 1'b1);
            serve(favour, -1);
            serve(favour, -1);
        end
    endtask

    task automatic test_read_stall;
        rand_hs = 0; stall_byte = 1; stall_cycles = 2;
        setup_req(1, 7'h55, 3, 1'b1);
        t_bytes[1][0] = 8'h11; t_bytes[1][1] = 8'h22; t_bytes[1][2] = 8'h33;
        serve(1, -1);
        stall_byte = -1; stall_cycles = 0;
    endtask

    task automatic test_len0;
        rand_hs = 0;
        setup_req(0, 7'h12, 0, 1'b0);
        serve(0, -1);
    endtask

    task automatic test_reset_mid;
        rand_hs = 0;
        setup_req(0, 7'h44, 4, 1'b0);
        serve(0, 1);
        setup_req(0, 7'h45, 2, 1'b0);
        serve(0, -1);
    endtask

    task automatic test_random;
        int mode, first;
        rand_hs = 1;
        for (int k = 0; k < 14; k++) begin
            mode = $urandom_range(0, 2);
            if (mode != 1) setup_req(0, 7'($urandom), $urandom_range(0, 6), 1'($urandom));
            if (mode != 0) setup_req(1, 7'($urandom), $urandom_range(0, 6), 1'($urandom));
            if (mode == 2) begin
                first = favour;
                serve(first, -1);
                serve(1 - first, -1);
            end else begin
                serve(mode, -1);
            end
        end
        rand_hs = 0;
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int waited, cyc;
        do_reset();
        setup_req(0, 7'h21, 2, 1'b0);
        waited = 0;
        do begin tick(); waited++; end while (gnt === 2'b00 && waited < 200);
        txValid[0] = 1'b1; mInReady = 1'b0;
        cyc = 0;
        do begin tick(); cyc++; end while (err !== 1'b1 && cyc < 300);
        n_cmp++;
        if (cyc != 101) begin
            n_bad++; $display("FAIL timeout latency: err after %0d cycles want 101", cyc);
        end
        n_cmp++;
        if ({done, gnt} !== 4'b0) begin
            n_bad++; $display("FAIL timeout abort: done=%b gnt=%b want 0", done, gnt);
        end
        txValid = 2'b00; req = 2'b00;
        tick();
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL timeout pulse width: err=%b want 0", err);
        end
        favour = 1;
        setup_req(0, 7'h22, 1, 1'b0);
        serve(0, -1);
    endtask
`endif

    initial begin
        #600000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        stall_byte = -1; stall_cycles = 0; rand_hs = 0; favour = 0;
        test_reset();
        test_write();
        test_round_robin();
        test_read_stall();
        test_len0();
        test_reset_mid();
        test_random();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
